// File: rtl/mem_port_arbiter.sv
// Owner of the shared data-memory port. The host gets the port in load and readout.
// In run the cores share it round-robin, and the arbiter tracks done flags and run time.
module mem_port_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  status,
   input  logic [ADDR_W-1:0]           com_addr,
   input  logic [DATA_W-1:0]           com_data_in,
   input  logic                        com_wr_en,
   output logic [DATA_W-1:0]           com_data_out,
   input  logic [NUM_CORES-1:0]        core_req,
   input  logic [NUM_CORES-1:0]        core_wr_en,
   input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
   input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
   input  logic [NUM_CORES-1:0]        core_done,
   output logic [NUM_CORES-1:0]        core_gnt,
   output logic [NUM_CORES-1:0]        core_rvalid,
   output logic [DATA_W-1:0]           core_rdata,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   output logic                        mem_wr_en,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic                        end_process,
   output logic [31:0]                 run_cycles
);

   localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int SUM_W = PTR_W + 1;
   localparam logic [1:0] ST_LOAD = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_READ = 2'b10;
   localparam logic [NUM_CORES-1:0] ALL_DONE = '1;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Modulo-NUM_CORES add that also works for non-power-of-two core counts.
   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                 input logic [PTR_W-1:0] off);
      logic [SUM_W-1:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= SUM_W'(NUM_CORES)) s = s - SUM_W'(NUM_CORES);
      return s[PTR_W-1:0];
   endfunction

   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_CORES-1:0] rvalid_q, rvalid_d;
   logic [NUM_CORES-1:0] done_mask_q, done_mask_d;
   logic                 end_q, end_d;
   logic [31:0]          cyc_q, cyc_d;
   logic [1:0]           prev_status_q;

   logic                 run_mode, host_mode, run_entry;
   logic [PTR_W-1:0]     scan_base, scan_idx, winner;
   logic                 win_vld;
   logic [NUM_CORES-1:0] gnt, done_acc;

   assign run_mode  = (status == ST_RUN);
   assign host_mode = (status == ST_LOAD) || (status == ST_READ);
   assign run_entry = run_mode && (prev_status_q != ST_RUN);
   // The pointer is cleared on run entry, yet that cycle must already arbitrate from 0.
   assign scan_base = run_entry ? '0 : rr_ptr_q;

   always_comb begin
      winner   = '0;
      win_vld  = 1'b0;
      scan_idx = '0;
      if (run_mode) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = wrap_add(scan_base, PTR_W'(k));
            if (!win_vld && core_req[scan_idx]) begin
               win_vld = 1'b1;
               winner  = scan_idx;
            end
         end
      end
   end

   always_comb begin
      gnt = '0;
      if (win_vld) gnt[winner] = 1'b1;
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wr_en = 1'b0;
      if (host_mode) begin
         mem_addr  = com_addr;
         mem_wdata = com_data_in;
         mem_wr_en = com_wr_en;
      end else if (run_mode) begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt[i]) begin
               mem_addr  = core_addr[i*ADDR_W +: ADDR_W];
               mem_wdata = core_wdata[i*DATA_W +: DATA_W];
               mem_wr_en = core_wr_en[i];
            end
         end
      end
   end

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      done_mask_d = done_mask_q;
      end_d       = end_q;
      cyc_d       = cyc_q;
      // Read return is keyed only on the grant, so a status change cannot drop it.
      rvalid_d    = gnt & ~core_wr_en;
      done_acc    = (run_entry ? '0 : done_mask_q) | core_done;
      if (win_vld) begin
         rr_ptr_d = wrap_add(winner, PTR_W'(1));
      end else if (run_entry) begin
         rr_ptr_d = '0;
      end
      if (run_mode) begin
         done_mask_d = done_acc;
         if (run_entry) begin
            end_d = (done_acc == ALL_DONE);
            cyc_d = sat_inc(32'd0);
         end else begin
            end_d = end_q | (done_acc == ALL_DONE);
            if (!end_q) cyc_d = sat_inc(cyc_q);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q      <= '0;
         rvalid_q      <= '0;
         done_mask_q   <= '0;
         end_q         <= 1'b0;
         cyc_q         <= '0;
         prev_status_q <= ST_LOAD;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         rvalid_q      <= rvalid_d;
         done_mask_q   <= done_mask_d;
         end_q         <= end_d;
         cyc_q         <= cyc_d;
         prev_status_q <= status;
      end
   end

   assign core_gnt     = gnt;
   assign core_rvalid  = rvalid_q;
   assign core_rdata   = mem_rdata;
   assign com_data_out = mem_rdata;
   assign end_process  = end_q;
   assign run_cycles   = cyc_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// compared each cycle against a behavioural model of the port rules.
module tb_mem_port_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      status;
   logic [AW-1:0]   com_addr;
   logic [DW-1:0]   com_data_in;
   logic            com_wr_en;
   logic [DW-1:0]   com_data_out;
   logic [N-1:0]    core_req, core_wr_en, core_done;
   logic [N*AW-1:0] core_addr;
   logic [N*DW-1:0] core_wdata;
   logic [N-1:0]    core_gnt, core_rvalid;
   logic [DW-1:0]   core_rdata;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_wr_en;
   logic [DW-1:0]   mem_rdata;
   logic            end_process;
   logic [31:0]     run_cycles;

   logic [AW-1:0]   a_arr [N];
   logic [DW-1:0]   d_arr [N];
   logic [DW-1:0]   mem   [256];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always_comb begin
      core_addr  = '0;
      core_wdata = '0;
      for (int i = 0; i < N; i++) begin
         core_addr[i*AW +: AW]  = a_arr[i];
         core_wdata[i*DW +: DW] = d_arr[i];
      end
   end

   // Stand-in data memory: synchronous read, one cycle latency.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 3);
      end else if (mem_wr_en) begin
         mem[mem_addr[7:0]] <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr[7:0]];
   end

   mem_port_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .status(status),
      .com_addr(com_addr), .com_data_in(com_data_in), .com_wr_en(com_wr_en),
      .com_data_out(com_data_out),
      .core_req(core_req), .core_wr_en(core_wr_en), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_done(core_done),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
      .mem_rdata(mem_rdata), .end_process(end_process), .run_cycles(run_cycles)
   );

   // Reference model state
   int          m_ptr;
   logic [1:0]  m_prev;
   logic [3:0]  m_mask;
   bit          m_end;
   longint      m_cyc;
   logic [3:0]  m_rv;
   logic [15:0] m_rd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr  = 0;
      m_prev = 2'b00;
      m_mask = 4'b0;
      m_end  = 1'b0;
      m_cyc  = 0;
      m_rv   = 4'b0;
      m_rd   = 16'h0;
   endtask

   // Checks outputs at the falling edge, then advances the model across the rising edge.
   task automatic step_cycle();
      int          win, p, nptr;
      bit          run, host, entry, all_d, nend;
      logic [1:0]  wi;
      logic [3:0]  eg, base, nmask, nrv;
      logic [15:0] ea, ew, nrd;
      logic        ewe;
      longint      ncyc;
      @(negedge clk);
      run   = (status == 2'b01);
      host  = (status == 2'b00) || (status == 2'b10);
      entry = run && (m_prev != 2'b01);
      p     = entry ? 0 : m_ptr;
      win   = -1;
      wi    = 2'b0;
      if (run) begin
         for (int k = 0; k < N; k++) begin
            if (win < 0 && core_req[2'((p + k) % N)]) win = (p + k) % N;
         end
      end
      eg = 4'b0; ea = 16'h0; ew = 16'h0; ewe = 1'b0;
      if (host) begin
         ea = com_addr; ew = com_data_in; ewe = com_wr_en;
      end else if (win >= 0) begin
         wi = 2'(win);
         eg = 4'b1 << wi;
         ea = a_arr[wi]; ew = d_arr[wi]; ewe = core_wr_en[wi];
      end
      chk("gnt", core_gnt, eg);
      chk("mem_addr", mem_addr, ea);
      chk("mem_wr_en", mem_wr_en, ewe);
      if (host || win >= 0 || status == 2'b11) chk("mem_wdata", mem_wdata, ew);
      chk("rvalid", core_rvalid, m_rv);
      chk("end_process", end_process, m_end);
      chk("run_cycles", run_cycles, m_cyc);
      if (m_rv != 4'b0) chk("core_rdata", core_rdata, m_rd);

      nrd   = mem[ea[7:0]];
      nrv   = (win >= 0 && !core_wr_en[wi]) ? eg : 4'b0;
      nptr  = (win >= 0) ? (win + 1) % N : (entry ? 0 : m_ptr);
      nmask = m_mask; nend = m_end; ncyc = m_cyc;
      if (run) begin
         base  = entry ? 4'b0 : m_mask;
         all_d = ((base | core_done) == 4'hF);
         nmask = base | core_done;
         if (entry) ncyc = 1;
         else if (!m_end && m_cyc < 64'hFFFF_FFFF) ncyc = m_cyc + 1;
         nend  = entry ? all_d : (m_end || all_d);
      end
      @(posedge clk);
      if (rst_n) begin
         m_rv = nrv; m_rd = nrd; m_ptr = nptr;
         m_mask = nmask; m_end = nend; m_cyc = ncyc; m_prev = status;
      end
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] rd_exp [3];
      logic [3:0]  skip_g [3];
      logic [15:0] skip_a [3];
      int          roll;
      rd_exp = '{16'd7, 16'd9, 16'd11};
      skip_g = '{4'b1000, 4'b0001, 4'b1000};
      skip_a = '{16'd43, 16'd40, 16'd43};

      rst_n = 1'b0; status = 2'b00;
      com_addr = '0; com_data_in = '0; com_wr_en = 1'b0;
      core_req = '0; core_wr_en = '0; core_done = '0;
      for (int i = 0; i < N; i++) begin a_arr[i] = '0; d_arr[i] = '0; end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_rvalid", core_rvalid, 0);
      chk("reset_end", end_process, 0);
      chk("reset_cycles", run_cycles, 0);
      rst_n = 1'b1;

      // Load: host writes while cores request (must not be granted)
      status = 2'b00; core_req = 4'hF; com_wr_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         com_addr = 16'(i); com_data_in = rd_exp[i];
         step_cycle();
      end
      com_addr = 16'd5; com_data_in = 16'h00AB;
      step_cycle();

      // Readout
      com_wr_en = 1'b0; status = 2'b10; com_addr = 16'd0;
      step_cycle();
      for (int i = 0; i < 3; i++) begin
         com_addr = 16'(i + 1);
         #1;
         chk("readout_data", com_data_out, rd_exp[i]);
         chk("readout_gnt", core_gnt, 0);
         step_cycle();
      end

      // Round-robin with all cores requesting reads
      status = 2'b01; core_req = 4'hF; core_wr_en = 4'h0;
      for (int i = 0; i < N; i++) a_arr[i] = 16'(16 + i);
      for (int k = 0; k < 8; k++) begin
         #1;
         chk("rr_gnt", core_gnt, 4'b1 << (k % 4));
         chk("rr_onehot", 64'($countones(core_gnt)), 1);
         step_cycle();
      end

      // Pointer skip: move pointer to 1, then cores 0 and 3 contend
      core_req = 4'b0001;
      step_cycle();
      core_req = 4'b1001; a_arr[0] = 16'd40; a_arr[3] = 16'd43;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("skip_gnt", core_gnt, skip_g[k]);
         chk("skip_addr", mem_addr, skip_a[k]);
         step_cycle();
      end

      // Read latency on core 2
      core_req = 4'b0100; a_arr[2] = 16'd5;
      #1;
      chk("lat_gnt", core_gnt, 4'b0100);
      step_cycle();
      core_req = 4'b0000;
      #1;
      chk("lat_rvalid", core_rvalid, 4'b0100);
      chk("lat_rdata", core_rdata, 16'h00AB);
      step_cycle();
      chk("lat_rvalid_clear", core_rvalid, 0);

      // Read in flight across a status change
      core_req = 4'b0010; a_arr[1] = 16'd1;
      step_cycle();
      status = 2'b10; core_req = 4'b0000;
      #1;
      chk("inflight_rvalid", core_rvalid, 4'b0010);
      chk("inflight_rdata", core_rdata, 16'd9);
      step_cycle();

      // Randomized traffic including mode changes and done pulses
      for (int c = 0; c < 400; c++) begin
         roll = int'($urandom_range(0, 15));
         status = (roll == 0) ? 2'b00 : (roll == 1) ? 2'b10 : (roll == 2) ? 2'b11 : 2'b01;
         core_req    = 4'($urandom);
         core_wr_en  = 4'($urandom);
         core_done   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
         com_addr    = 16'($urandom_range(16, 47));
         com_data_in = 16'($urandom);
         com_wr_en   = 1'($urandom);
         for (int i = 0; i < N; i++) begin
            a_arr[i] = 16'($urandom_range(16, 47));
            d_arr[i] = 16'($urandom);
         end
         step_cycle();
      end

      // end_process and cycle counter with staggered done pulses
      status = 2'b10; core_req = 4'b0; core_done = 4'b0; com_wr_en = 1'b0;
      step_cycle();
      status = 2'b01;
      for (int c = 0; c <= 45; c++) begin
         core_done = (c == 10) ? 4'b0001 : (c == 20) ? 4'b0010 :
                     (c == 30) ? 4'b0100 : (c == 40) ? 4'b1000 : 4'b0000;
         step_cycle();
         if (c == 39) chk("end_before", end_process, 0);
         if (c == 40) begin
            chk("end_set", end_process, 1);
            chk("cycles_at_end", run_cycles, 41);
         end
         if (c == 45) chk("cycles_frozen", run_cycles, 41);
      end
      core_done = 4'b0; status = 2'b10;
      step_cycle();
      chk("readout_end_hold", end_process, 1);
      chk("readout_cycles_hold", run_cycles, 41);
      status = 2'b01;
      step_cycle();
      chk("reentry_end", end_process, 0);
      chk("reentry_cycles", run_cycles, 1);
      step_cycle();
      chk("reentry_count", run_cycles, 2);

      // Async reset during contended reads with end_process set
      core_req = 4'hF; core_wr_en = 4'h0; core_done = 4'hF;
      step_cycle();
      core_done = 4'h0;
      repeat (3) step_cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rvalid", core_rvalid, 0);
      chk("async_end", end_process, 0);
      chk("async_cycles", run_cycles, 0);
      model_reset();
      step_cycle();
      rst_n = 1'b1;
      #1;
      chk("post_reset_gnt", core_gnt, 4'b0001);
      repeat (5) step_cycle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
